// File: rtl/bandit_environment.sv
// bandit_environment
//   Multi-armed bandit environment. Accepts an arm index on the action
//   channel, looks up that arm's programmed mean, optionally adds LFSR
//   noise, and returns a saturated signed 8-bit reward. Also tracks the
//   best-programmed arm and counts how often the agent picks it.
//
// Build option:
//   BANDIT_ENVIRONMENT_NOISE_EN  defined   -> noise = lfsr[NOISE_BITS-1:0] (signed)
//                                undefined -> noise = 0, reward = mean exactly
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   action_valid/ready/data agent -> environment arm selection
//   reward_valid/ready/data environment -> agent signed reward
//   config_valid/index/data mean table write port (accepted every cycle)
//   best_index              arm with the highest programmed mean
//   hit_count               accepted actions equal to best_index (saturating)
//
// state   | meaning
// IDLE    | waiting for an action (action_ready=1)
// LOOKUP  | read mean[arm], form saturated reward
// RESPOND | reward_valid=1, hold reward_data until reward_ready
// 2'b11   | illegal, recovers to IDLE

module bandit_environment #(
  parameter logic [7:0] SEED       = 8'h5a,
  parameter logic [7:0] TAPS       = 8'hb1,
  parameter int         NOISE_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        action_valid,
  input  logic [7:0]  action_data,
  output logic        action_ready,
  output logic        reward_valid,
  output logic [7:0]  reward_data,
  input  logic        reward_ready,
  input  logic        config_valid,
  input  logic [7:0]  config_index,
  input  logic [7:0]  config_data,
  output logic [7:0]  best_index,
  output logic [15:0] hit_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOOKUP  = 2'b01,
    RESPOND = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t            state;
  logic [7:0]        arm;
  logic [7:0]        lfsr;
  logic [7:0]        best_mean;
  logic [7:0]        mean_table [256];
  logic [7:0]        mean_rd;
  logic signed [9:0] mean_ext;
  logic signed [9:0] noise_ext;
  logic signed [9:0] sum;
  logic [7:0]        reward_sat;

  assign action_ready = (state == IDLE);
  assign reward_valid = (state == RESPOND);

  // Table is not reset; a write in the LOOKUP cycle lands after the read,
  // so the reward is built from the old mean.
  always_ff @(posedge clock) begin
    if (config_valid) mean_table[config_index] <= config_data;
  end

  assign mean_rd  = mean_table[arm];
  assign mean_ext = {{2{mean_rd[7]}}, mean_rd};

`ifdef BANDIT_ENVIRONMENT_NOISE_EN
  assign noise_ext = 10'($signed(lfsr[NOISE_BITS-1:0]));
`else
  assign noise_ext = '0;
`endif

  assign sum = mean_ext + noise_ext;

  always_comb begin
    reward_sat = sum[7:0];
    if (sum > 10'sd127)       reward_sat = 8'h7f;
    else if (sum < -10'sd128) reward_sat = 8'h80;
  end

  // LFSR runs every cycle regardless of handshake state or build option.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[6:0], ^(lfsr & TAPS)};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      arm         <= '0;
      reward_data <= '0;
      hit_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (action_valid) begin
            arm   <= action_data;
            state <= LOOKUP;
            // best_index here is the pre-write value of any same-cycle config
            if (action_data == best_index && hit_count != 16'hffff)
              hit_count <= hit_count + 16'd1;
          end
        end
        LOOKUP: begin
          reward_data <= reward_sat;
          state       <= RESPOND;
        end
        RESPOND: begin
          if (reward_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Best tracking follows writes only; lowering the current best's mean
  // keeps its index even if another arm is now higher.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_index <= '0;
      best_mean  <= '0;
    end else if (config_valid) begin
      if (config_index == best_index) begin
        best_mean <= config_data;
      end else if ($signed(config_data) > $signed(best_mean)) begin
        best_index <= config_index;
        best_mean  <= config_data;
      end
    end
  end

endmodule

// File: tb/tb_bandit_environment.sv
module tb_bandit_environment;

  logic        clock = 1'b0;
  logic        reset;
  logic        action_valid;
  logic [7:0]  action_data;
  logic        action_ready;
  logic        reward_valid;
  logic [7:0]  reward_data;
  logic        reward_ready;
  logic        config_valid;
  logic [7:0]  config_index;
  logic [7:0]  config_data;
  logic [7:0]  best_index;
  logic [15:0] hit_count;

  int checks = 0;
  int errors = 0;

`ifdef BANDIT_ENVIRONMENT_NOISE_EN
  localparam int NLO = -8;
  localparam int NHI = 7;
`else
  localparam int NLO = 0;
  localparam int NHI = 0;
`endif

  bandit_environment #(.SEED(8'h5a), .TAPS(8'hb1), .NOISE_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .action_valid(action_valid), .action_data(action_data), .action_ready(action_ready),
    .reward_valid(reward_valid), .reward_data(reward_data), .reward_ready(reward_ready),
    .config_valid(config_valid), .config_index(config_index), .config_data(config_data),
    .best_index(best_index), .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b1;
    action_valid = 1'b0; action_data = '0; reward_ready = 1'b0;
    config_valid = 1'b0; config_index = '0; config_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic write_mean(input logic [7:0] idx, input logic [7:0] val);
    @(negedge clock);
    config_valid = 1'b1; config_index = idx; config_data = val;
    @(posedge clock);
    #1 config_valid = 1'b0;
  endtask

  task automatic send_action(input logic [7:0] arm, output logic [7:0] rdata);
    int n;
    @(negedge clock);
    reward_ready = 1'b1; action_valid = 1'b1; action_data = arm;
    n = 0;
    while (!action_ready && n < 20) begin @(negedge clock); n++; end
    @(posedge clock);
    @(negedge clock) action_valid = 1'b0;
    n = 0;
    while (!reward_valid && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (reward_valid !== 1'b1) begin
      errors++;
      $display("FAIL send_action_timeout arm=%0d: reward_valid=%b required 1", arm, reward_valid);
    end
    rdata = reward_data;
    @(posedge clock);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (action_ready !== 1'b1) begin errors++; $display("FAIL reset_action_ready: got %b required 1", action_ready); end
    checks++; if (reward_valid !== 1'b0) begin errors++; $display("FAIL reset_reward_valid: got %b required 0", reward_valid); end
    checks++; if (reward_data !== 8'h00) begin errors++; $display("FAIL reset_reward_data: got %h required 00", reward_data); end
    checks++; if (hit_count !== 16'h0) begin errors++; $display("FAIL reset_hit_count: got %0d required 0", hit_count); end
    checks++; if (best_index !== 8'h0) begin errors++; $display("FAIL reset_best_index: got %0d required 0", best_index); end
  endtask

  task automatic test_latency();
    apply_reset();
    write_mean(8'd7, 8'd20);
    @(negedge clock);
    reward_ready = 1'b1; action_valid = 1'b1; action_data = 8'd7;
    checks++; if (action_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_idle: got %b required 1", action_ready); end
    @(posedge clock);
    @(negedge clock) action_valid = 1'b0;
    checks++; if (action_ready !== 1'b0 || reward_valid !== 1'b0) begin errors++;
      $display("FAIL lat_lookup: ready=%b valid=%b required 0 0", action_ready, reward_valid); end
    @(negedge clock);
    checks++; if (action_ready !== 1'b0 || reward_valid !== 1'b1) begin errors++;
      $display("FAIL lat_respond: ready=%b valid=%b required 0 1", action_ready, reward_valid); end
    checks++; if (int'($signed(reward_data)) < 20 + NLO || int'($signed(reward_data)) > 20 + NHI) begin errors++;
      $display("FAIL lat_reward_data: got %0d required 20", $signed(reward_data)); end
    @(negedge clock);
    checks++; if (action_ready !== 1'b1 || reward_valid !== 1'b0) begin errors++;
      $display("FAIL lat_back_idle: ready=%b valid=%b required 1 0", action_ready, reward_valid); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL lat_hit_count: got %0d required 1", hit_count); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    reward_ready = 1'b0; action_valid = 1'b1; action_data = 8'd7;
    @(posedge clock);
    @(negedge clock) action_valid = 1'b0;
    @(negedge clock);
    checks++; if (reward_valid !== 1'b1) begin errors++; $display("FAIL mid_respond: reward_valid=%b required 1", reward_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (reward_valid !== 1'b0 || action_ready !== 1'b1 || reward_data !== 8'h00) begin errors++;
      $display("FAIL mid_async_reset: valid=%b ready=%b data=%h required 0 1 00", reward_valid, action_ready, reward_data); end
    @(negedge clock) reset = 1'b0;
  endtask

  task automatic test_best_hits();
    logic [7:0] r;
    apply_reset();
    write_mean(8'd3, 8'd50);
    checks++; if (best_index !== 8'd3) begin errors++; $display("FAIL best_first: got %0d required 3", best_index); end
    write_mean(8'd11, 8'd50);
    checks++; if (best_index !== 8'd3) begin errors++; $display("FAIL best_tie: got %0d required 3", best_index); end
    write_mean(8'd9, 8'd40);
    checks++; if (best_index !== 8'd3) begin errors++; $display("FAIL best_lower: got %0d required 3", best_index); end
    write_mean(8'd3, 8'd10);
    checks++; if (best_index !== 8'd3) begin errors++; $display("FAIL best_rewrite: got %0d required 3", best_index); end
    write_mean(8'd14, 8'h90);
    checks++; if (best_index !== 8'd3) begin errors++; $display("FAIL best_signed: got %0d required 3", best_index); end
    send_action(8'd3, r);
    checks++; if (int'($signed(r)) < 10 + NLO || int'($signed(r)) > 10 + NHI) begin errors++; $display("FAIL hit_reward3: got %0d required 10", $signed(r)); end
    send_action(8'd3, r);
    send_action(8'd9, r);
    checks++; if (int'($signed(r)) < 40 + NLO || int'($signed(r)) > 40 + NHI) begin errors++; $display("FAIL hit_reward9: got %0d required 40", $signed(r)); end
    checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL hit_count_two: got %0d required 2", hit_count); end
    write_mean(8'd13, 8'd11);
    checks++; if (best_index !== 8'd13) begin errors++; $display("FAIL best_new: got %0d required 13", best_index); end
    // accept of arm 13 in the same cycle that a write moves best to arm 20
    @(negedge clock);
    reward_ready = 1'b1; action_valid = 1'b1; action_data = 8'd13;
    config_valid = 1'b1; config_index = 8'd20; config_data = 8'd100;
    @(posedge clock);
    #1 config_valid = 1'b0;
    @(negedge clock) action_valid = 1'b0;
    checks++; if (best_index !== 8'd20) begin errors++; $display("FAIL best_same_cycle: got %0d required 20", best_index); end
    @(negedge clock);
    checks++; if (int'($signed(reward_data)) < 11 + NLO || int'($signed(reward_data)) > 11 + NHI) begin errors++;
      $display("FAIL hit_reward13: got %0d required 11", $signed(reward_data)); end
    @(negedge clock);
    checks++; if (hit_count !== 16'd3) begin errors++; $display("FAIL hit_old_best: got %0d required 3", hit_count); end
  endtask

  task automatic test_stall();
    logic [7:0] d0;
    @(negedge clock);
    reward_ready = 1'b0; action_valid = 1'b1; action_data = 8'd7;
    @(posedge clock);
    @(negedge clock) action_data = 8'd9;
    @(negedge clock);
    d0 = reward_data;
    checks++; if (reward_valid !== 1'b1 || int'($signed(d0)) < 20 + NLO || int'($signed(d0)) > 20 + NHI) begin errors++;
      $display("FAIL stall_enter: valid=%b data=%0d required 1 20", reward_valid, $signed(d0)); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (reward_valid !== 1'b1 || reward_data !== d0 || action_ready !== 1'b0) begin errors++;
        $display("FAIL stall_hold cycle %0d: valid=%b data=%h ready=%b required 1 %h 0", i, reward_valid, reward_data, action_ready, d0); end
    end
    reward_ready = 1'b1;
    @(negedge clock);
    checks++; if (action_ready !== 1'b1 || reward_valid !== 1'b0) begin errors++;
      $display("FAIL stall_release: ready=%b valid=%b required 1 0", action_ready, reward_valid); end
    @(negedge clock);
    checks++; if (action_ready !== 1'b0) begin errors++; $display("FAIL stall_next_accept: ready=%b required 0", action_ready); end
    action_valid = 1'b0;
    @(negedge clock);
    checks++; if (reward_valid !== 1'b1 || int'($signed(reward_data)) < 40 + NLO || int'($signed(reward_data)) > 40 + NHI) begin errors++;
      $display("FAIL stall_next_reward: valid=%b data=%0d required 1 40", reward_valid, $signed(reward_data)); end
    @(posedge clock);
  endtask

  task automatic test_read_before_write();
    logic [7:0] r;
    write_mean(8'd5, 8'd30);
    @(negedge clock);
    reward_ready = 1'b1; action_valid = 1'b1; action_data = 8'd5;
    @(posedge clock);
    @(negedge clock);
    action_valid = 1'b0;
    config_valid = 1'b1; config_index = 8'd5; config_data = 8'd60;
    @(posedge clock);
    #1 config_valid = 1'b0;
    @(negedge clock);
    checks++; if (int'($signed(reward_data)) < 30 + NLO || int'($signed(reward_data)) > 30 + NHI) begin errors++;
      $display("FAIL rbw_old_mean: got %0d required 30", $signed(reward_data)); end
    @(posedge clock);
    send_action(8'd5, r);
    checks++; if (int'($signed(r)) < 60 + NLO || int'($signed(r)) > 60 + NHI) begin errors++;
      $display("FAIL rbw_new_mean: got %0d required 60", $signed(r)); end
  endtask

  task automatic test_saturation();
    logic [7:0] r;
    int n;
    write_mean(8'd1, 8'd125);
    write_mean(8'd2, 8'h82);
`ifdef BANDIT_ENVIRONMENT_NOISE_EN
    n = 200;
`else
    n = 4;
`endif
    for (int i = 0; i < n; i++) begin
      send_action(8'd1, r);
      checks++;
      if (int'($signed(r)) < 125 + NLO || int'($signed(r)) > 127) begin errors++;
        $display("FAIL sat_high iter %0d: got %0d required %0d..127", i, $signed(r), 125 + NLO); end
    end
    for (int i = 0; i < n; i++) begin
      send_action(8'd2, r);
      checks++;
      if (int'($signed(r)) < -128 || int'($signed(r)) > -126 + NHI) begin errors++;
        $display("FAIL sat_low iter %0d: got %0d required -128..%0d", i, $signed(r), -126 + NHI); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_reset_mid();
    test_best_hits();
    test_stall();
    test_read_before_write();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
